// File: rtl/axi_pkg.sv
// Shared AXI3 constants and the RAM slave's state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // AXI3 burst length field width (beats-1, up to 16 beats).
    localparam int LEN_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        WR    = 2'd2,
        WRESP = 2'd3
    } state_e;

endpackage

// File: rtl/byte_wr_ram.sv
// 32-bit word RAM: combinational read, synchronous write with per-byte strobes.
// Latency: read 0 cycles (combinational); write lands on the next posedge clk.
// Backpressure: none, always accepts a write; contents are never reset.
//
// Ports: clk; we/be/addr/wdata form the write port; rdata shows mem[addr].
// Read and write share one address, since the slave only ever touches the
// word it is currently bursting on.
module byte_wr_ram #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    localparam int DEPTH = 1 << AW;

    // Per-byte write enables; each lane is its own array so no lane is
    // ever partially driven by another lane's write process.
    logic [3:0] byte_we;
    assign byte_we = {4{we}} & be;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];

        always_ff @(posedge clk) begin
            if (byte_we[i]) begin
                lane_mem[addr] <= wdata[8*i +: 8];
            end
        end

        assign rdata[8*i +: 8] = lane_mem[addr];
    end

endmodule

// File: rtl/axi_ram_slave.sv
// AXI3 slave responder over a word-addressed RAM, one transaction at a time.
// Latency: AR handshake -> first rvalid 1 cycle; last W beat -> bvalid 1 cycle.
// Backpressure: rready/bready stall with outputs held; reads win AR/AW ties.
//
// Ports: AXI3 AR/R/AW/W/B channels on clk with synchronous active-low resetn.
// arsize/awsize and wid are accepted but ignored: every beat is 32 bits.
module axi_ram_slave
    import axi_pkg::*;
#(
    parameter int          ADDR_W = 16,
    parameter logic [31:0] BASE   = 32'h0000_0000,
    parameter int          ID_W   = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [ID_W-1:0]  arid,
    input  logic [31:0]      araddr,
    input  logic [3:0]       arlen,
    input  logic [2:0]       arsize,
    input  logic             arvalid,
    output logic             arready,
    output logic [ID_W-1:0]  rid,
    output logic [31:0]      rdata,
    output logic [1:0]       rresp,
    output logic             rlast,
    output logic             rvalid,
    input  logic             rready,
    input  logic [ID_W-1:0]  awid,
    input  logic [31:0]      awaddr,
    input  logic [3:0]       awlen,
    input  logic [2:0]       awsize,
    input  logic             awvalid,
    output logic             awready,
    input  logic [ID_W-1:0]  wid,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    input  logic             wlast,
    input  logic             wvalid,
    output logic             wready,
    output logic [ID_W-1:0]  bid,
    output logic [1:0]       bresp,
    output logic             bvalid,
    input  logic             bready
);

    localparam int WA_W = ADDR_W - 2;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   id_q,    id_d;
    logic [WA_W-1:0]   wa_q,    wa_d;
    logic [LEN_W-1:0]  len_q,   len_d;
    logic [LEN_W-1:0]  cnt_q,   cnt_d;
    logic              oor_q,   oor_d;
    logic              err_q,   err_d;

    logic              mem_we;
    logic [31:0]       mem_rdata;

    // Offsets from BASE; an address below BASE wraps to a huge offset and so
    // lands out of range as well.
    logic [31:0] ar_off, aw_off;
    logic        ar_oor, aw_oor;
    assign ar_off = araddr - BASE;
    assign aw_off = awaddr - BASE;
    assign ar_oor = |ar_off[31:ADDR_W];
    assign aw_oor = |aw_off[31:ADDR_W];

    logic unused_ok;
    assign unused_ok = ^{arsize, awsize, wid, ar_off[1:0], aw_off[1:0]};

    byte_wr_ram #(.AW(WA_W)) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .be    (wstrb),
        .addr  (wa_q),
        .wdata (wdata),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        wa_d    = wa_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        oor_d   = oor_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        arready = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        rid     = '0;
        rdata   = '0;
        rresp   = RESP_OKAY;
        bvalid  = 1'b0;
        bid     = '0;
        bresp   = RESP_OKAY;

        case (state_q)
            IDLE: begin
                arready = 1'b1;
                awready = ~arvalid;
                if (arvalid) begin
                    state_d = RD;
                    id_d    = arid;
                    wa_d    = ar_off[ADDR_W-1:2];
                    len_d   = arlen;
                    cnt_d   = '0;
                    oor_d   = ar_oor;
                end else if (awvalid) begin
                    state_d = WR;
                    id_d    = awid;
                    wa_d    = aw_off[ADDR_W-1:2];
                    len_d   = awlen;
                    cnt_d   = '0;
                    oor_d   = aw_oor;
                end
            end

            RD: begin
                rvalid = 1'b1;
                rid    = id_q;
                rdata  = oor_q ? 32'h0 : mem_rdata;
                rresp  = oor_q ? RESP_SLVERR : RESP_OKAY;
                rlast  = (cnt_q == len_q);
                if (rready) begin
                    // Index wraps modulo the RAM depth by natural overflow.
                    wa_d  = wa_q + WA_W'(1);
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q) begin
                        state_d = IDLE;
                    end
                end
            end

            WR: begin
                wready = 1'b1;
                if (wvalid) begin
                    mem_we = ~oor_q;
                    if (oor_q) begin
                        err_d = 1'b1;
                    end
                    wa_d  = wa_q + WA_W'(1);
                    cnt_d = cnt_q + LEN_W'(1);
                    // An early wlast or a missing one both end the burst.
                    if (wlast || (cnt_q == len_q)) begin
                        state_d = WRESP;
                    end
                end
            end

            WRESP: begin
                bvalid = 1'b1;
                bid    = id_q;
                bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
                if (bready) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            id_q    <= '0;
            wa_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            oor_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            wa_q    <= wa_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            oor_q   <= oor_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Self-checking bench for axi_ram_slave: table of transactions + corner sequences.
// Expected beats/responses come from a reference memory model via scoreboard queues.
// Outputs are sampled 1-2 time units after posedge; inputs change just after posedge.
module tb_axi_ram_slave;

    localparam int          ADDR_W = 16;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam int          ID_W   = 4;
    localparam int          DEPTH  = 1 << (ADDR_W - 2);
    localparam int          TMO    = 100;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [ID_W-1:0] arid = '0, awid = '0, wid = '0;
    logic [31:0]     araddr = '0, awaddr = '0, wdata = '0;
    logic [3:0]      arlen = '0, awlen = '0, wstrb = '0;
    logic [2:0]      arsize = 3'b010, awsize = 3'b010;
    logic            arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
    logic            rready = 1'b0, bready = 1'b0;
    logic            arready, awready, wready, rvalid, rlast, bvalid;
    logic [ID_W-1:0] rid, bid;
    logic [31:0]     rdata;
    logic [1:0]      rresp, bresp;

    always #5 clk = ~clk;

    axi_ram_slave #(.ADDR_W(ADDR_W), .BASE(BASE), .ID_W(ID_W)) dut (
        .clk(clk), .resetn(resetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rexp_t;

    typedef struct {
        logic [1:0] resp;
        logic [3:0] id;
    } bexp_t;

    rexp_t rq[$];
    bexp_t bq[$];
    logic [31:0] model_mem [int];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_get(input int idx);
        return model_mem.exists(idx) ? model_mem[idx] : 32'h0;
    endfunction

    function automatic bit model_oor(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return (off >> ADDR_W) != 0;
    endfunction

    function automatic int model_idx(input logic [31:0] addr, input int beat);
        logic [31:0] off;
        off = addr - BASE;
        return (int'(off >> 2) + beat) % DEPTH;
    endfunction

    task automatic model_read(input logic [3:0] id, input logic [31:0] addr,
                              input logic [3:0] len, input logic [1:0] resp);
        rexp_t e;
        for (int b = 0; b <= int'(len); b++) begin
            e.data = model_oor(addr) ? 32'h0 : model_get(model_idx(addr, b));
            e.resp = resp;
            e.last = (b == int'(len));
            e.id   = id;
            rq.push_back(e);
        end
    endtask

    task automatic model_write(input logic [3:0] id, input logic [31:0] addr,
                               input logic [3:0] len, input logic [31:0] data,
                               input logic [3:0] strb, input logic [1:0] resp);
        bexp_t e;
        logic [31:0] w, d;
        int idx;
        if (!model_oor(addr)) begin
            for (int b = 0; b <= int'(len); b++) begin
                idx = model_idx(addr, b);
                w = model_get(idx);
                d = data + b;
                for (int i = 0; i < 4; i++)
                    if (strb[i]) w[8*i +: 8] = d[8*i +: 8];
                model_mem[idx] = w;
            end
        end
        e.resp = resp;
        e.id   = id;
        bq.push_back(e);
    endtask

    task automatic ar_hs(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
        int t = 0;
        arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
        #1;
        while (!arready && t < TMO) begin @(posedge clk); #1; t++; end
        chk("arready", arready, 1'b1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("rvalid_first_latency", rvalid, 1'b1);
    endtask

    task automatic r_beats(input int nbeats, input bit stall);
        rexp_t e;
        int t;
        for (int b = 0; b < nbeats; b++) begin
            t = 0;
            while (!rvalid && t < TMO) begin @(posedge clk); #1; t++; end
            chk("rvalid", rvalid, 1'b1);
            if (rq.size() == 0) begin
                chk("r_scoreboard_empty", 32'd1, 32'd0);
                return;
            end
            e = rq.pop_front();
            if (stall) begin
                rready = 1'b0;
                @(posedge clk); #1;
                chk("rdata_stall", rdata, e.data);
                chk("rlast_stall", rlast, e.last);
                chk("rid_stall", rid, e.id);
                chk("rresp_stall", rresp, e.resp);
            end
            rready = 1'b1;
            #1;
            chk("rdata", rdata, e.data);
            chk("rresp", rresp, e.resp);
            chk("rlast", rlast, e.last);
            chk("rid", rid, e.id);
            @(posedge clk); #1;
        end
        rready = 1'b0;
    endtask

    task automatic aw_hs(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
        int t = 0;
        awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
        #1;
        while (!awready && t < TMO) begin @(posedge clk); #1; t++; end
        chk("awready", awready, 1'b1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        chk("wready_after_aw", wready, 1'b1);
    endtask

    task automatic w_beats(input logic [3:0] len, input logic [31:0] data, input logic [3:0] strb);
        int t;
        for (int b = 0; b <= int'(len); b++) begin
            wdata = data + b; wstrb = strb; wlast = (b == int'(len)); wvalid = 1'b1;
            #1;
            t = 0;
            while (!wready && t < TMO) begin @(posedge clk); #1; t++; end
            chk("wready", wready, 1'b1);
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("bvalid_latency", bvalid, 1'b1);
    endtask

    task automatic b_check();
        bexp_t e;
        int t = 0;
        while (!bvalid && t < TMO) begin @(posedge clk); #1; t++; end
        chk("bvalid", bvalid, 1'b1);
        if (bq.size() == 0) begin
            chk("b_scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = bq.pop_front();
        chk("bresp", bresp, e.resp);
        chk("bid", bid, e.id);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        chk("bvalid_cleared", bvalid, 1'b0);
    endtask

    typedef struct {
        bit          wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [31:0] data;
        logic [3:0]  strb;
        bit          stall;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 4'h1, 32'h0000_0010, 4'd0, 32'hDEAD_BEEF, 4'hF, 1'b0, 2'b00};
        vecs[1] = '{1'b0, 4'h2, 32'h0000_0010, 4'd0, 32'h0,        4'h0, 1'b0, 2'b00};
        vecs[2] = '{1'b1, 4'h3, 32'h0000_0020, 4'd0, 32'h1122_3344, 4'hF, 1'b0, 2'b00};
        vecs[3] = '{1'b1, 4'h4, 32'h0000_0020, 4'd0, 32'hAABB_CCDD, 4'h5, 1'b0, 2'b00};
        vecs[4] = '{1'b0, 4'h5, 32'h0000_0020, 4'd0, 32'h0,        4'h0, 1'b0, 2'b00};
        vecs[5] = '{1'b1, 4'h6, 32'h0000_0040, 4'd3, 32'h0,        4'hF, 1'b0, 2'b00};
        vecs[6] = '{1'b0, 4'h7, 32'h0000_0040, 4'd3, 32'h0,        4'h0, 1'b1, 2'b00};
        vecs[7] = '{1'b1, 4'h8, 32'h0000_FFF8, 4'd3, 32'hC0DE_0000, 4'hF, 1'b0, 2'b00};
        vecs[8] = '{1'b0, 4'h9, 32'h0000_FFF8, 4'd3, 32'h0,        4'h0, 1'b0, 2'b00};
        vecs[9] = '{1'b1, 4'hA, 32'h0000_0000, 4'd0, 32'h5A5A_0001, 4'hF, 1'b0, 2'b00};

        // Reset state
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        #1;
        chk("rst_arready", arready, 1'b1);
        chk("rst_awready", awready, 1'b1);
        chk("rst_wready", wready, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rlast", rlast, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rdata", rdata, 32'h0);

        // Table of transactions
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].wr) begin
                model_write(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].data,
                            vecs[v].strb, vecs[v].exp_resp);
                aw_hs(vecs[v].id, vecs[v].addr, vecs[v].len);
                w_beats(vecs[v].len, vecs[v].data, vecs[v].strb);
                b_check();
            end else begin
                model_read(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].exp_resp);
                ar_hs(vecs[v].id, vecs[v].addr, vecs[v].len);
                r_beats(int'(vecs[v].len) + 1, vecs[v].stall);
                chk("rvalid_idle_after_burst", rvalid, 1'b0);
            end
        end
        chk("model_bytestrobe_word", model_get(8), 32'h11BB_33DD);

        // Simultaneous AR and AW: read wins, write follows
        model_read(4'hC, 32'h10, 4'd0, 2'b00);
        model_write(4'hB, 32'h80, 4'd0, 32'hCAFE_F00D, 4'hF, 2'b00);
        awid = 4'hB; awaddr = 32'h80; awlen = 4'd0; awvalid = 1'b1;
        arid = 4'hC; araddr = 32'h10; arlen = 4'd0; arvalid = 1'b1;
        #1;
        chk("tie_awready", awready, 1'b0);
        chk("tie_arready", arready, 1'b1);
        ar_hs(4'hC, 32'h10, 4'd0);
        chk("awready_during_rd", awready, 1'b0);
        r_beats(1, 1'b0);
        aw_hs(4'hB, 32'h80, 4'd0);
        w_beats(4'd0, 32'hCAFE_F00D, 4'hF);
        b_check();
        model_read(4'hD, 32'h80, 4'd0, 2'b00);
        ar_hs(4'hD, 32'h80, 4'd0);
        r_beats(1, 1'b0);

        // Out of range read and write; word 0 must survive the write
        model_read(4'h1, BASE + 32'h0001_0000, 4'd1, 2'b10);
        ar_hs(4'h1, BASE + 32'h0001_0000, 4'd1);
        r_beats(2, 1'b0);
        model_write(4'h2, BASE + 32'h0001_0000, 4'd0, 32'hBAD0_BAD0, 4'hF, 2'b10);
        aw_hs(4'h2, BASE + 32'h0001_0000, 4'd0);
        w_beats(4'd0, 32'hBAD0_BAD0, 4'hF);
        b_check();
        model_read(4'h3, 32'h0, 4'd0, 2'b00);
        ar_hs(4'h3, 32'h0, 4'd0);
        r_beats(1, 1'b0);
        chk("model_word0", model_get(0), 32'h5A5A_0001);

        // Reset in the middle of a read burst
        model_read(4'h4, 32'h40, 4'd3, 2'b00);
        ar_hs(4'h4, 32'h40, 4'd3);
        r_beats(1, 1'b0);
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        chk("midrst_rvalid", rvalid, 1'b0);
        chk("midrst_bvalid", bvalid, 1'b0);
        chk("midrst_arready", arready, 1'b1);
        rq.delete();
        model_read(4'h5, 32'h10, 4'd0, 2'b00);
        ar_hs(4'h5, 32'h10, 4'd0);
        r_beats(1, 1'b0);

        chk("rq_drained", rq.size(), 0);
        chk("bq_drained", bq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
